// File: rtl/regfile_write_arbiter_if.sv
// regfile_write_arbiter_if: writeback bus between NUM_REQ requesters, the arbiter and the regfile write port.
// Signals:
//   req_valid/req_ready     per-requester handshake (ready is one-hot or zero)
//   req_address/req_data    packed per-requester destination register and data
//   wb_hold                 blocks new grants for the cycle
//   rd_address/rd_data      regfile write port (address 0 = no write)
//   wb_valid/wb_grant_id    output stage holds a real write / its source index
//   RF_WB_FWD_EN adds rs1/rs2 read addresses, raw regfile read data and forwarded read data.
// Modports: master = requester/regfile side, slave = arbiter.
interface regfile_write_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int XLEN    = 32,
    parameter int ADDR_W  = 5
);
    localparam int ID_W = $clog2(NUM_REQ);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*ADDR_W-1:0] req_address;
    logic [NUM_REQ*XLEN-1:0]   req_data;
    logic                      wb_hold;
    logic [ADDR_W-1:0]         rd_address;
    logic [XLEN-1:0]           rd_data;
    logic                      wb_valid;
    logic [ID_W-1:0]           wb_grant_id;
`ifdef RF_WB_FWD_EN
    logic [ADDR_W-1:0]         rs1_address, rs2_address;
    logic [XLEN-1:0]           rs1_rf_data, rs2_rf_data;
    logic [XLEN-1:0]           rs1_data, rs2_data;
    modport master (
        output req_valid, req_address, req_data, wb_hold,
        output rs1_address, rs2_address, rs1_rf_data, rs2_rf_data,
        input  req_ready, rd_address, rd_data, wb_valid, wb_grant_id,
        input  rs1_data, rs2_data
    );
    modport slave (
        input  req_valid, req_address, req_data, wb_hold,
        input  rs1_address, rs2_address, rs1_rf_data, rs2_rf_data,
        output req_ready, rd_address, rd_data, wb_valid, wb_grant_id,
        output rs1_data, rs2_data
    );
`else
    modport master (
        output req_valid, req_address, req_data, wb_hold,
        input  req_ready, rd_address, rd_data, wb_valid, wb_grant_id
    );
    modport slave (
        input  req_valid, req_address, req_data, wb_hold,
        output req_ready, rd_address, rd_data, wb_valid, wb_grant_id
    );
`endif
endinterface

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: round-robin share of the single regfile write port among NUM_REQ writeback sources.
// Ports:
//   clk    clock, all state on posedge
//   reset  synchronous active-high reset
//   bus    regfile_write_arbiter_if.slave (handshake, write port, optional forwarding)
// Optional feature: define RF_WB_FWD_EN to compile in output-stage forwarding to the rs1/rs2 read ports.
// Idle cycles drive rd_address=0 because the regfile writes every clock and x0 writes are discarded.
module regfile_write_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int XLEN    = 32,
    parameter int ADDR_W  = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    regfile_write_arbiter_if.slave bus
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [ID_W-1:0]    rr_q, rr_d, gid;
    logic [ID_W-1:0]    wb_grant_id_q, wb_grant_id_d;
    logic [NUM_REQ-1:0] grant;
    logic               xfer;
    logic [ADDR_W-1:0]  sel_addr, rd_address_q, rd_address_d;
    logic [XLEN-1:0]    sel_data, rd_data_q, rd_data_d;
    logic               wb_valid_q, wb_valid_d;

    always_comb begin
        gid = rr_q;
        // Scan from the farthest position back to rr_ptr so the closest valid requester wins.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (bus.req_valid[ID_W'((int'(rr_q) + k) % NUM_REQ)]) gid = ID_W'((int'(rr_q) + k) % NUM_REQ);
        end
        // Ready is independent of address/data; zero during reset or hold.
        grant = (reset || bus.wb_hold || !(|bus.req_valid)) ? '0 : ({{(NUM_REQ-1){1'b0}}, 1'b1} << gid);
        xfer = |grant;
        sel_addr = bus.req_address[gid*ADDR_W +: ADDR_W];
        sel_data = bus.req_data[gid*XLEN +: XLEN];
        rr_d = xfer ? ((gid == ID_W'(NUM_REQ - 1)) ? '0 : gid + 1'b1) : rr_q;
        rd_address_d = xfer ? sel_addr : '0;
        rd_data_d = xfer ? sel_data : rd_data_q;
        wb_valid_d = xfer && (sel_addr != '0);
        wb_grant_id_d = xfer ? gid : wb_grant_id_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_q          <= '0;
            rd_address_q  <= '0;
            rd_data_q     <= '0;
            wb_valid_q    <= 1'b0;
            wb_grant_id_q <= '0;
        end else begin
            rr_q          <= rr_d;
            rd_address_q  <= rd_address_d;
            rd_data_q     <= rd_data_d;
            wb_valid_q    <= wb_valid_d;
            wb_grant_id_q <= wb_grant_id_d;
        end
    end

    assign bus.req_ready   = grant;
    assign bus.rd_address  = rd_address_q;
    assign bus.rd_data     = rd_data_q;
    assign bus.wb_valid    = wb_valid_q;
    assign bus.wb_grant_id = wb_grant_id_q;

`ifdef RF_WB_FWD_EN
    // x0 never forwards since wb_valid is low for x0 writes.
    assign bus.rs1_data = (wb_valid_q && bus.rs1_address == rd_address_q) ? rd_data_q : bus.rs1_rf_data;
    assign bus.rs2_data = (wb_valid_q && bus.rs2_address == rd_address_q) ? rd_data_q : bus.rs2_rf_data;
`endif
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: table-driven, scoreboarded bench for regfile_write_arbiter (NUM_REQ=2).
module tb_regfile_write_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    regfile_write_arbiter_if #(.NUM_REQ(2), .XLEN(32), .ADDR_W(5)) bus ();
    regfile_write_arbiter #(.NUM_REQ(2), .XLEN(32), .ADDR_W(5)) dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct {
        logic [1:0]  valid;
        logic        hold;
        logic [4:0]  a0, a1;
        logic [31:0] d0, d1;
        logic [1:0]  rdy;
        logic [4:0]  ea;
        logic [31:0] ed;
        logic        ewv;
        logic        egid;
    } vec_t;

    typedef struct {
        logic [4:0]  ea;
        logic [31:0] ed;
        logic        ewv;
        logic        egid;
    } exp_t;

    exp_t sbq[$];
    vec_t vt[14];

    function automatic vec_t mk(logic [1:0] valid, logic hold, logic [4:0] a0, logic [31:0] d0,
                                logic [4:0] a1, logic [31:0] d1, logic [1:0] rdy,
                                logic [4:0] ea, logic [31:0] ed, logic ewv, logic egid);
        vec_t v;
        v.valid = valid; v.hold = hold; v.a0 = a0; v.d0 = d0; v.a1 = a1; v.d1 = d1;
        v.rdy = rdy; v.ea = ea; v.ed = ed; v.ewv = ewv; v.egid = egid;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_out(input logic [4:0] ea, input logic [31:0] ed, input logic ewv, input logic egid);
        chk("rd_address", 32'(bus.rd_address), 32'(ea));
        chk("rd_data", bus.rd_data, ed);
        chk("wb_valid", 32'(bus.wb_valid), 32'(ewv));
        chk("wb_grant_id", 32'(bus.wb_grant_id), 32'(egid));
    endtask

    task automatic apply(input vec_t v);
        exp_t e;
        @(negedge clk);
        bus.req_valid   = v.valid;
        bus.wb_hold     = v.hold;
        bus.req_address = {v.a1, v.a0};
        bus.req_data    = {v.d1, v.d0};
        #1;
        chk("req_ready", 32'(bus.req_ready), 32'(v.rdy));
        sbq.push_back('{ea: v.ea, ed: v.ed, ewv: v.ewv, egid: v.egid});
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        check_out(e.ea, e.ed, e.ewv, e.egid);
    endtask

    initial begin
        bus.req_valid   = 2'b11;
        bus.wb_hold     = 1'b0;
        bus.req_address = {5'd2, 5'd1};
        bus.req_data    = {32'h200, 32'h100};
`ifdef RF_WB_FWD_EN
        bus.rs1_address = '0; bus.rs2_address = '0;
        bus.rs1_rf_data = '0; bus.rs2_rf_data = '0;
`endif
        // Both valid, grants 0,1,0,1 back to back; then single write, idle, x0, hold, release, wrap.
        vt[0]  = mk(2'b11, 0, 5'd1, 32'h100,      5'd2, 32'h200,      2'b01, 5'd1, 32'h100,      1, 0);
        vt[1]  = mk(2'b11, 0, 5'd1, 32'h100,      5'd2, 32'h200,      2'b10, 5'd2, 32'h200,      1, 1);
        vt[2]  = mk(2'b11, 0, 5'd1, 32'h100,      5'd2, 32'h200,      2'b01, 5'd1, 32'h100,      1, 0);
        vt[3]  = mk(2'b11, 0, 5'd1, 32'h100,      5'd2, 32'h200,      2'b10, 5'd2, 32'h200,      1, 1);
        vt[4]  = mk(2'b01, 0, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0,        2'b01, 5'd5, 32'hDEADBEEF, 1, 0);
        vt[5]  = mk(2'b00, 0, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0,        2'b00, 5'd0, 32'hDEADBEEF, 0, 0);
        vt[6]  = mk(2'b10, 0, 5'd0, 32'h0,        5'd0, 32'h1234,     2'b10, 5'd0, 32'h1234,     0, 1);
        vt[7]  = mk(2'b11, 1, 5'd6, 32'h600,      5'd7, 32'h700,      2'b00, 5'd0, 32'h1234,     0, 1);
        vt[8]  = mk(2'b11, 1, 5'd6, 32'h600,      5'd7, 32'h700,      2'b00, 5'd0, 32'h1234,     0, 1);
        vt[9]  = mk(2'b11, 1, 5'd6, 32'h600,      5'd7, 32'h700,      2'b00, 5'd0, 32'h1234,     0, 1);
        vt[10] = mk(2'b11, 0, 5'd6, 32'h600,      5'd7, 32'h700,      2'b01, 5'd6, 32'h600,      1, 0);
        vt[11] = mk(2'b10, 0, 5'd0, 32'h0,        5'd7, 32'hA5A5A5A5, 2'b10, 5'd7, 32'hA5A5A5A5, 1, 1);
        vt[12] = mk(2'b10, 0, 5'd0, 32'h0,        5'd7, 32'hA5A5A5A5, 2'b10, 5'd7, 32'hA5A5A5A5, 1, 1);
        vt[13] = mk(2'b00, 0, 5'd0, 32'h0,        5'd0, 32'h0,        2'b00, 5'd0, 32'hA5A5A5A5, 0, 1);

        @(negedge clk);
        #1;
        chk("ready_in_reset", 32'(bus.req_ready), 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        check_out(5'd0, 32'h0, 1'b0, 1'b0);
        reset = 1'b0;

        for (int i = 0; i < 14; i++) begin
            apply(vt[i]);
`ifdef RF_WB_FWD_EN
            if (i == 11) begin
                bus.rs1_address = 5'd7; bus.rs1_rf_data = 32'h0;
                bus.rs2_address = 5'd0; bus.rs2_rf_data = 32'h55;
                #1;
                chk("rs1_fwd", bus.rs1_data, 32'hA5A5A5A5);
                chk("rs2_x0_nofwd", bus.rs2_data, 32'h55);
            end
`endif
        end

        // Reset while a write sits in the output stage, then pointer returns to 0.
        @(negedge clk);
        bus.req_valid = 2'b01; bus.req_address = {5'd3, 5'd9}; bus.req_data = {32'h300, 32'h900};
        #1;
        chk("pre_rst_ready", 32'(bus.req_ready), 32'h1);
        @(posedge clk);
        #1;
        chk("pre_rst_addr", 32'(bus.rd_address), 32'd9);
        @(negedge clk);
        reset = 1'b1; bus.req_valid = 2'b11;
        #1;
        chk("mid_rst_ready", 32'(bus.req_ready), 32'h0);
        @(posedge clk);
        #1;
        check_out(5'd0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("post_rst_ready", 32'(bus.req_ready), 32'h1);
        @(posedge clk);
        #1;
        check_out(5'd9, 32'h900, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
